piso_shift: RTL and testbench
=============================

# piso_shift

Parallel-in/serial-out shifter that produces the single-bit stream consumed by the team's serial delay/shift chains. A word is accepted on a valid/ready handshake, then driven out on `y` one bit per bit period with a qualifying strobe and a last-bit flag. It sits between word-oriented logic and any serial sink. It supports gap-free back-to-back frames.

## Interface
- `DATA_W`, 8, word width in bits; legal range ≥2.
- `BIT_DIV`, 1, clock cycles per serial bit; legal range ≥1.

- `sys_clk` in 1: single clock, all logic on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `din` in DATA_W: parallel word to serialize.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: block can accept a word this cycle.
- `y` out 1: serial data bit.
- `y_valid` out 1: `y` carries a frame bit.
- `y_last` out 1: `y` carries the final bit of the frame.
- `busy` out 1: a frame is being shifted.

## Operation
- State machine has two states, IDLE and SHIFT.
- Internal registers:
  - shift register `sr[DATA_W-1:0]`
  - bit counter `bit_cnt`, counting 0..DATA_W-1, width clog2(DATA_W)
  - divider counter `div_cnt`, counting 0..BIT_DIV-1, width clog2(BIT_DIV), minimum 1
- A transfer occurs on a rising edge where `din_valid && din_ready`.
- `din_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT only during the final cycle of the last bit: `bit_cnt==DATA_W-1 && div_cnt==BIT_DIV-1`.
  - 0 otherwise.
- IDLE → SHIFT on a transfer. The edge loads `sr` with `din` and clears `bit_cnt` and `div_cnt`.
- In SHIFT:
  - `div_cnt` increments every cycle and wraps at BIT_DIV-1.
  - On the wrap, `sr` shifts by one position and `bit_cnt` increments.
- Leaving SHIFT at the end of the last bit:
  - With a transfer on the same edge: reload `sr`, clear the counters, stay in SHIFT. There is no idle cycle between frames.
  - Without a transfer: SHIFT → IDLE.
- Outputs:
  - `y = sr[DATA_W-1]` (MSB first) while in SHIFT; forced 0 in IDLE.
  - `y_valid = busy = (state==SHIFT)`.
  - `y_last = (state==SHIFT) && bit_cnt==DATA_W-1`, held for all BIT_DIV cycles of the last bit.
- `din` is sampled only on a transfer edge. Later changes to `din` have no effect on the frame in flight.
- A `din_valid` that is held while `din_ready`=0 is not accepted and not lost. It is accepted on the first ready cycle.
- Reset mid-frame: all state clears immediately and the frame is abandoned. No partial frame resumes after reset is released.

## Timing
- Reset values: `y`=0, `y_valid`=0, `y_last`=0, `busy`=0, state=IDLE.
- `din_ready` becomes 1 as soon as state is IDLE. No transfer is taken while `sys_rst_n`=0.
- Latency: transfer at edge N → first bit on `y` with `y_valid`=1 in cycle N+1.
- Each bit is stable on `y` for exactly BIT_DIV cycles.
- Frame length is DATA_W×BIT_DIV cycles.
- `y_last` covers cycles N+1+(DATA_W-1)×BIT_DIV through N+DATA_W×BIT_DIV.
- Back-to-back frames: `y_valid` stays 1 continuously. The first bit of the next frame directly follows the last bit of the current frame.
- All outputs except `din_ready` are registered or decoded from registered state only. They have no combinational path from `din` or `din_valid`.

## Configuration
- Macro: `PISO_LSB_FIRST_EN`.
- Defined: `y = sr[0]`, and `sr` shifts right, so the LSB is sent first.
- Undefined (default): `y = sr[DATA_W-1]`, and `sr` shifts left, so the MSB is sent first.
- Handshake, counters, `y_last` and all timing are identical in both builds.

## Test plan
- MSB-first frame (DATA_W=8, BIT_DIV=1):
  - Stimulus: transfer 8'hC1 at edge 0.
  - Required: `y`=1,1,0,0,0,0,0,1 in cycles 1–8; `y_valid`=1 in cycles 1–8; `y_last`=1 in cycle 8 only; `y`=0 and `y_valid`=0 in cycle 9.
- Back-to-back frames:
  - Stimulus: 8'hC1, then 8'h3C offered with `din_valid` held high.
  - Required: second transfer lands at edge 8 (`din_ready`=1 only in cycles 0 and 8); `y` = C1 bits then 0,0,1,1,1,1,0,0 in cycles 9–16; `y_valid` never drops.
- Bit divider (BIT_DIV=3):
  - Stimulus: transfer 8'hC1.
  - Required: each bit held 3 cycles; `y_valid` high for 24 cycles; `y_last` high in cycles 22–24.
- Backpressure:
  - Stimulus: `din_valid`=1 with a changing `din` during a frame.
  - Required: `din_ready`=0 until the last cycle; the in-flight frame is unchanged; the value of `din` present at the ready edge is the one captured.
- Reset mid-frame:
  - Stimulus: assert `sys_rst_n`=0 during bit 4 of 8'hC1.
  - Required: `y`, `y_valid`, `y_last` and `busy` go to 0 asynchronously; after release `din_ready`=1; a fresh 8'hA5 serializes cleanly.
- LSB-first build (`PISO_LSB_FIRST_EN` defined):
  - Stimulus: transfer 8'hC1.
  - Required: `y`=1,0,0,0,0,0,1,1 in cycles 1–8; `y_last` timing unchanged.

Source files
------------

// File: rtl/piso_shift.sv
// Parallel-in/serial-out shifter: accepts a word on valid/ready and streams it on y,
// one bit per BIT_DIV cycles. Define PISO_LSB_FIRST_EN to send the LSB first (default MSB first).
module piso_shift #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BIT_DIV = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              y,
  output logic              y_valid,
  output logic              y_last,
  output logic              busy
);

  localparam int unsigned BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned DIV_CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   sr, sr_nxt;
  logic [BIT_CW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [DIV_CW-1:0]   div_cnt, div_cnt_nxt;
  logic                bit_last;
  logic                div_last;
  logic                xfer;
  logic [DATA_W-1:0]   sr_shifted;
  logic                sr_out;

  assign bit_last = (bit_cnt == BIT_CW'(DATA_W - 1));
  assign div_last = (div_cnt == DIV_CW'(BIT_DIV - 1));

  // Ready is the one combinational output: open in IDLE or on the final cycle of the last bit.
  assign din_ready = (state == IDLE) || (bit_last && div_last);
  assign xfer      = din_valid && din_ready;

`ifdef PISO_LSB_FIRST_EN
  assign sr_shifted = {1'b0, sr[DATA_W-1:1]};
  assign sr_out     = sr[0];
`else
  assign sr_shifted = {sr[DATA_W-2:0], 1'b0};
  assign sr_out     = sr[DATA_W-1];
`endif

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      bit_cnt <= bit_cnt_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt   = SHIFT;
          sr_nxt      = din;
          bit_cnt_nxt = '0;
          div_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (!div_last) begin
          div_cnt_nxt = div_cnt + DIV_CW'(1);
        end else if (!bit_last) begin
          div_cnt_nxt = '0;
          bit_cnt_nxt = bit_cnt + BIT_CW'(1);
          sr_nxt      = sr_shifted;
        end else begin
          // End of frame: a same-edge transfer chains the next frame with no gap.
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          if (xfer) begin
            sr_nxt = din;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Serial outputs are decoded from registered state only.
  always_comb begin
    busy    = (state == SHIFT);
    y_valid = busy;
    y_last  = busy && bit_last;
    y       = busy && sr_out;
  end

endmodule

// File: tb/tb_piso_shift.sv
// Directed bench for piso_shift: one DATA_W=8/BIT_DIV=1 instance and one BIT_DIV=3 instance.
module tb_piso_shift;

  logic       clk;
  logic       rst_a, rst_b;
  logic [7:0] din_a, din_b;
  logic       vld_a, vld_b;
  logic       rdy_a, rdy_b;
  logic       y_a, y_b;
  logic       yv_a, yv_b;
  logic       yl_a, yl_b;
  logic       busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  piso_shift #(.DATA_W(8), .BIT_DIV(1)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_a), .din(din_a), .din_valid(vld_a),
    .din_ready(rdy_a), .y(y_a), .y_valid(yv_a), .y_last(yl_a), .busy(busy_a)
  );

  piso_shift #(.DATA_W(8), .BIT_DIV(3)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_b), .din(din_b), .din_valid(vld_b),
    .din_ready(rdy_b), .y(y_b), .y_valid(yv_b), .y_last(yl_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected serial bit i (0 = first sent) of an 8-bit word.
  function automatic logic exp_bit(input logic [7:0] w, input int i);
`ifdef PISO_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    din_a = '0;   din_b = '0;
    vld_a = 1'b0; vld_b = 1'b0;
    tick(); tick();

    chk("rst_y",     y_a,    1'b0);
    chk("rst_valid", yv_a,   1'b0);
    chk("rst_last",  yl_a,   1'b0);
    chk("rst_busy",  busy_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    rst_a = 1'b1; rst_b = 1'b1;
    tick();

    // Single frame 8'hC1, cycle 0 is the transfer cycle
    din_a = 8'hC1; vld_a = 1'b1;
    chk("f1_ready0", rdy_a, 1'b1);
    tick();
    vld_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("f1_y%0d", k),     y_a,   exp_bit(8'hC1, k-1));
      chk($sformatf("f1_valid%0d", k), yv_a,  1'b1);
      chk($sformatf("f1_last%0d", k),  yl_a,  k == 8);
      chk($sformatf("f1_ready%0d", k), rdy_a, k == 8);
      tick();
    end
    chk("f1_y_after",     y_a,  1'b0);
    chk("f1_valid_after", yv_a, 1'b0);
    chk("f1_busy_after",  busy_a, 1'b0);
    tick();

    // Back-to-back: 8'hC1 then 8'h3C with valid held high
    din_a = 8'hC1; vld_a = 1'b1;
    chk("b2b_ready0", rdy_a, 1'b1);
    tick();
    din_a = 8'h3C;
    for (int k = 1; k <= 16; k++) begin
      logic [7:0] w;
      w = (k <= 8) ? 8'hC1 : 8'h3C;
      chk($sformatf("b2b_y%0d", k),     y_a,   exp_bit(w, (k-1) % 8));
      chk($sformatf("b2b_valid%0d", k), yv_a,  1'b1);
      chk($sformatf("b2b_last%0d", k),  yl_a,  (k == 8) || (k == 16));
      if (k <= 8) chk($sformatf("b2b_ready%0d", k), rdy_a, k == 8);
      tick();
      if (k == 8) vld_a = 1'b0;
    end
    chk("b2b_valid_after", yv_a, 1'b0);
    tick();

    // Backpressure: din changes while not ready; value at the ready edge is captured
    din_a = 8'hA5; vld_a = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      din_a = (k == 8) ? 8'h5A : 8'(8'h10 + k);
      chk($sformatf("bp_y%0d", k),     y_a,   exp_bit(8'hA5, k-1));
      chk($sformatf("bp_ready%0d", k), rdy_a, k == 8);
      tick();
    end
    vld_a = 1'b0;
    din_a = 8'hFF;
    for (int k = 9; k <= 16; k++) begin
      chk($sformatf("bp_y%0d", k),    y_a,  exp_bit(8'h5A, k-9));
      chk($sformatf("bp_last%0d", k), yl_a, k == 16);
      tick();
    end
    chk("bp_valid_after", yv_a, 1'b0);
    tick();

    // Reset mid-frame during bit 4 of 8'hC1
    din_a = 8'hC1; vld_a = 1'b1;
    tick();
    vld_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mr_y%0d", k), y_a, exp_bit(8'hC1, k-1));
      if (k < 4) tick();
    end
    chk("mr_valid_pre", yv_a, 1'b1);
    #2 rst_a = 1'b0;
    #1;
    chk("mr_y",     y_a,    1'b0);
    chk("mr_valid", yv_a,   1'b0);
    chk("mr_last",  yl_a,   1'b0);
    chk("mr_busy",  busy_a, 1'b0);
    tick(); tick();
    rst_a = 1'b1;
    tick();
    chk("mr_ready_idle", rdy_a, 1'b1);
    chk("mr_busy_idle",  busy_a, 1'b0);
    din_a = 8'hA5; vld_a = 1'b1;
    tick();
    vld_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("mr2_y%0d", k),    y_a,  exp_bit(8'hA5, k-1));
      chk($sformatf("mr2_last%0d", k), yl_a, k == 8);
      tick();
    end
    chk("mr2_valid_after", yv_a, 1'b0);

    // Bit divider of 3 on the second instance
    din_b = 8'hC1; vld_b = 1'b1;
    chk("div_ready0", rdy_b, 1'b1);
    tick();
    vld_b = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      chk($sformatf("div_y%0d", k),     y_b,   exp_bit(8'hC1, (k-1) / 3));
      chk($sformatf("div_valid%0d", k), yv_b,  1'b1);
      chk($sformatf("div_last%0d", k),  yl_b,  k >= 22);
      chk($sformatf("div_ready%0d", k), rdy_b, k == 24);
      tick();
    end
    chk("div_valid_after", yv_b, 1'b0);
    chk("div_y_after",     y_b,  1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
